control_sequencer: RTL and testbench

- Hardwired control unit that generates the per-cycle control strobes for the dataPath, replacing hand-coded testbench state sequences.
- Runs the fetch (T0–T2) and a decode cycle, then an opcode-dependent execute sequence.
- Supports ldi, ld, st, register ALU ops, immediate ALU ops, nop and halt, with memory wait states, a wait timeout and run/stop control.

---
 rtl/control_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : control_sequencer                                           |
// | Brief  : Hardwired control unit. Sequences fetch (T0-T2), decode and |
// |          opcode-dependent execute states, and emits the per-cycle    |
// |          dataPath strobes. Handles memory wait states with a timeout |
// |          and run/stop control.                                       |
// | Option : CU_SINGLE_STEP_EN - return to IDLE after every instruction. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module control_sequencer #(
  parameter int IR_W       = 32,
  parameter int OPC_W      = 5,
  parameter int ALU_CTRL_W = 4,
  parameter int WAIT_MAX   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  stop,
  input  logic [IR_W-1:0]       ir,
  input  logic                  mem_ready,
  output logic                  PCout,
  output logic                  Zlowout,
  output logic                  MDRout,
  output logic                  MARin,
  output logic                  Zlowin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  IncPc,
  output logic                  Cout,
  output logic                  BAout,
  output logic                  Gra,
  output logic                  Grb,
  output logic                  Grc,
  output logic                  Rin,
  output logic                  Rout,
  output logic                  read,
  output logic                  write,
  output logic [1:0]            mdr_read,
  output logic [ALU_CTRL_W-1:0] control,
  output logic                  running,
  output logic                  instr_done,
  output logic                  illegal,
  output logic                  mem_err
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, DEC = 4'd4,
    E1   = 4'd5, E2 = 4'd6, E3 = 4'd7, E4 = 4'd8, E5  = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CL_LDI = 3'd0, CL_LD = 3'd1, CL_ST = 3'd2, CL_RALU = 3'd3,
    CL_IALU = 3'd4, CL_NOP = 3'd5, CL_HALT = 3'd6, CL_BAD = 3'd7
  } opcls_t;

  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'b00001);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01000);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(5'b01001);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(5'b01010);
  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(5'b11110);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11111);
  localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);

  function automatic opcls_t op_class(input logic [OPC_W-1:0] op);
    case (op)
      OP_LDI:                         return CL_LDI;
      OP_LD:                          return CL_LD;
      OP_ST:                          return CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  return CL_RALU;
      OP_ADDI, OP_ANDI, OP_ORI:       return CL_IALU;
      OP_NOP:                         return CL_NOP;
      OP_HALT:                        return CL_HALT;
      default:                        return CL_BAD;
    endcase
  endfunction

  function automatic logic [ALU_CTRL_W-1:0] alu_code(input logic [OPC_W-1:0] op);
    case (op)
      OP_AND, OP_ANDI: return ALU_CTRL_W'(0);
      OP_OR,  OP_ORI:  return ALU_CTRL_W'(1);
      OP_SUB:          return ALU_CTRL_W'(3);
      default:         return ALU_CTRL_W'(2);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;

  logic [OPC_W-1:0] w_opc_live;
  opcls_t           w_cls_live;
  opcls_t           w_cls;
  state_t           w_after_last;
  logic             w_timeout;
  logic             unused_ir;

  assign w_opc_live = ir[IR_W-1 -: OPC_W];
  assign w_cls_live = op_class(w_opc_live);
  assign w_cls      = op_class(op_q);
  assign w_timeout  = !mem_ready && (wait_q == WAIT_LAST);

`ifdef CU_SINGLE_STEP_EN
  logic unused_stop;
  assign unused_stop  = stop;
  assign w_after_last = IDLE;
`else
  assign w_after_last = stop ? IDLE : T0;
`endif

  assign unused_ir = ^ir[IR_W-OPC_W-1:0];
  assign illegal   = illegal_q;
  assign mem_err   = mem_err_q;

  // Next-state, latched opcode, wait counter and sticky error flags.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    case (state_q)
      IDLE: if (run) begin
        state_d   = T0;
        illegal_d = 1'b0;
        mem_err_d = 1'b0;
      end
      T0: begin
        state_d = T1;
        wait_d  = '0;
      end
      T1: begin
        if (mem_ready)      state_d = T2;
        else if (w_timeout) begin state_d = IDLE; mem_err_d = 1'b1; end
        else                wait_d = wait_q + 8'd1;
      end
      T2:  state_d = DEC;
      DEC: begin
        op_d = w_opc_live;
        case (w_cls_live)
          CL_NOP:  state_d = w_after_last;
          CL_HALT: state_d = IDLE;
          CL_BAD:  begin state_d = IDLE; illegal_d = 1'b1; end
          default: state_d = E1;
        endcase
      end
      E1: state_d = E2;
      E2: state_d = E3;
      E3: begin
        if (w_cls == CL_LD || w_cls == CL_ST) begin
          state_d = E4;
          wait_d  = '0;
        end else begin
          state_d = w_after_last;
        end
      end
      E4: begin
        if (w_cls == CL_ST)  begin state_d = E5; wait_d = '0; end
        else if (mem_ready)  state_d = E5;
        else if (w_timeout)  begin state_d = IDLE; mem_err_d = 1'b1; end
        else                 wait_d = wait_q + 8'd1;
      end
      E5: begin
        if (w_cls != CL_ST || mem_ready) state_d = w_after_last;
        else if (w_timeout)              begin state_d = IDLE; mem_err_d = 1'b1; end
        else                             wait_d = wait_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; asynchronous reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Strobe decode from the current state; the store's done pulse is gated by
  // mem_ready so it fires once, on the cycle the write actually completes.
  always_comb begin
    {PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPc,
     Cout, BAout, Gra, Grb, Grc, Rin, Rout, read, write} = '0;
    mdr_read   = 2'b00;
    control    = '0;
    instr_done = 1'b0;
    running    = (state_q != IDLE);
    case (state_q)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zlowin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; mdr_read = 2'b01; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      DEC: instr_done = (w_cls_live == CL_NOP) || (w_cls_live == CL_HALT);
      E1: begin
        Grb = 1'b1;
        Yin = 1'b1;
        if (w_cls == CL_RALU || w_cls == CL_IALU) Rout  = 1'b1;
        else                                      BAout = 1'b1;
      end
      E2: begin
        Zlowin  = 1'b1;
        control = alu_code(op_q);
        if (w_cls == CL_RALU) begin Grc = 1'b1; Rout = 1'b1; end
        else                  Cout = 1'b1;
      end
      E3: begin
        Zlowout = 1'b1;
        if (w_cls == CL_LD || w_cls == CL_ST) MARin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
      end
      E4: begin
        MDRin = 1'b1;
        if (w_cls == CL_ST) begin Gra = 1'b1; Rout = 1'b1; end
        else                begin read = 1'b1; mdr_read = 2'b01; end
      end
      E5: begin
        if (w_cls == CL_ST) begin write = 1'b1; instr_done = mem_ready; end
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_control_sequencer                                        |
// | Brief  : Directed, table-driven bench for control_sequencer plus     |
// |          hand-written reset, timeout and wait-boundary sequences.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_control_sequencer;

  logic clk, reset, run, stop, mem_ready;
  logic [31:0] ir;
  logic PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPc;
  logic Cout, BAout, Gra, Grb, Grc, Rin, Rout, read, write;
  logic [1:0] mdr_read;
  logic [3:0] control;
  logic running, instr_done, illegal, mem_err;

  control_sequencer #(.IR_W(32), .OPC_W(5), .ALU_CTRL_W(4), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .run(run), .stop(stop), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zlowin(Zlowin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPc(IncPc), .Cout(Cout),
    .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .read(read), .write(write), .mdr_read(mdr_read), .control(control),
    .running(running), .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bit positions inside the packed snapshot (PCout is the MSB).
  localparam logic [18:0] PCOUT = 19'h40000, ZLO  = 19'h20000, MDRO = 19'h10000;
  localparam logic [18:0] MARI  = 19'h08000, ZLI  = 19'h04000, PCI  = 19'h02000;
  localparam logic [18:0] MDRI  = 19'h01000, IRI  = 19'h00800, YI   = 19'h00400;
  localparam logic [18:0] INC   = 19'h00200, COUT = 19'h00100, BAO  = 19'h00080;
  localparam logic [18:0] GRA   = 19'h00040, GRB  = 19'h00020, GRC  = 19'h00010;
  localparam logic [18:0] RIN   = 19'h00008, ROUT = 19'h00004, RD   = 19'h00002;
  localparam logic [18:0] WR    = 19'h00001;

  // Expected snapshots: {strobes, mdr_read, control, running, done, illegal, mem_err}.
  localparam logic [28:0] E_IDLE  = 29'h0;
  localparam logic [28:0] E_ILL   = 29'h2;
  localparam logic [28:0] E_MERR  = 29'h1;
  localparam logic [28:0] E_T0    = {PCOUT | MARI | INC | ZLI, 2'b00, 4'd0, 4'b1000};
  localparam logic [28:0] E_T1    = {ZLO | PCI | RD | MDRI,    2'b01, 4'd0, 4'b1000};
  localparam logic [28:0] E_T2    = {MDRO | IRI,               2'b00, 4'd0, 4'b1000};
  localparam logic [28:0] E_DEC   = {19'd0,                    2'b00, 4'd0, 4'b1000};
  localparam logic [28:0] E_DECD  = {19'd0,                    2'b00, 4'd0, 4'b1100};
  localparam logic [28:0] E_E1L   = {GRB | BAO | YI,           2'b00, 4'd0, 4'b1000};
  localparam logic [28:0] E_E2L   = {COUT | ZLI,               2'b00, 4'd2, 4'b1000};
  localparam logic [28:0] E_E3R   = {ZLO | GRA | RIN,          2'b00, 4'd0, 4'b1100};
  localparam logic [28:0] E_E3M   = {ZLO | MARI,               2'b00, 4'd0, 4'b1000};
  localparam logic [28:0] E_E4LD  = {RD | MDRI,                2'b01, 4'd0, 4'b1000};
  localparam logic [28:0] E_E4ST  = {GRA | ROUT | MDRI,        2'b00, 4'd0, 4'b1000};
  localparam logic [28:0] E_E5LD  = {MDRO | GRA | RIN,         2'b00, 4'd0, 4'b1100};
  localparam logic [28:0] E_E5ST  = {WR,                       2'b00, 4'd0, 4'b1000};
  localparam logic [28:0] E_E5STD = {WR,                       2'b00, 4'd0, 4'b1100};
  localparam logic [28:0] E_E1A   = {GRB | ROUT | YI,          2'b00, 4'd0, 4'b1000};
  localparam logic [28:0] E_E2SUB = {GRC | ROUT | ZLI,         2'b00, 4'd3, 4'b1000};
  localparam logic [28:0] E_E2AND = {COUT | ZLI,               2'b00, 4'd0, 4'b1000};
  localparam logic [28:0] E_E2ADD = {COUT | ZLI,               2'b00, 4'd2, 4'b1000};

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, SUB = 5'b00100;
  localparam logic [4:0] ADDI = 5'b01000, ANDI = 5'b01001, NOP = 5'b11110, HALT = 5'b11111;
  localparam logic [4:0] BAD = 5'b10111;

  typedef struct {
    logic        run;
    logic        stop;
    logic        mr;
    logic [4:0]  opc;
    logic [28:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [28:0] snap();
    return {PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPc,
            Cout, BAout, Gra, Grb, Grc, Rin, Rout, read, write,
            mdr_read, control, running, instr_done, illegal, mem_err};
  endfunction

  task automatic add(input logic r, input logic s, input logic m, input logic [4:0] o,
                     input logic [28:0] e, input string n);
    vec_t v;
    v.run = r; v.stop = s; v.mr = m; v.opc = o; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic s, input logic m, input logic [4:0] o);
    run = r; stop = s; mem_ready = m; ir = {o, 27'h2ABCDEF};
  endtask

  task automatic check(input string n, input logic [28:0] e);
    logic [28:0] act;
    act = snap();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, e);
    end
  endtask

  // Settle, compare the current cycle, then advance one clock.
  task automatic expect_step(input string n, input logic [28:0] e);
    #1;
    check(n, e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 1, NOP);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 1, NOP);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", E_IDLE);
    reset = 1'b1;

    // ldi, continuous into sub with stop ignored until the last state.
    add(0,0,1,LDI,E_IDLE,"idle");      add(1,0,1,LDI,E_IDLE,"idle_run");
    add(0,0,1,LDI,E_T0,"ldi_t0");      add(0,0,1,LDI,E_T1,"ldi_t1");
    add(0,0,1,LDI,E_T2,"ldi_t2");      add(0,0,1,LDI,E_DEC,"ldi_dec");
    add(0,0,1,LDI,E_E1L,"ldi_e1");     add(0,0,1,LDI,E_E2L,"ldi_e2");
    add(0,0,1,LDI,E_E3R,"ldi_e3");
    add(0,0,1,SUB,E_T0,"ldi_next_t0"); add(0,0,1,SUB,E_T1,"sub_t1");
    add(0,0,1,SUB,E_T2,"sub_t2");      add(0,0,1,SUB,E_DEC,"sub_dec");
    add(0,1,1,SUB,E_E1A,"sub_e1");     add(0,1,1,SUB,E_E2SUB,"sub_e2");
    add(0,1,1,SUB,E_E3R,"sub_e3_stop");
    add(1,0,1,LD,E_IDLE,"sub_idle");
    // ld with 3 fetch wait states and 2 memory wait states.
    add(0,0,1,LD,E_T0,"ld_t0");
    add(0,0,0,LD,E_T1,"ld_t1_w0");     add(0,0,0,LD,E_T1,"ld_t1_w1");
    add(0,0,0,LD,E_T1,"ld_t1_w2");     add(0,0,1,LD,E_T1,"ld_t1_rdy");
    add(0,0,1,LD,E_T2,"ld_t2");        add(0,0,1,LD,E_DEC,"ld_dec");
    add(0,0,1,LD,E_E1L,"ld_e1");       add(0,0,1,LD,E_E2L,"ld_e2");
    add(0,0,1,LD,E_E3M,"ld_e3");
    add(0,0,0,LD,E_E4LD,"ld_e4_w0");   add(0,0,0,LD,E_E4LD,"ld_e4_w1");
    add(0,0,1,LD,E_E4LD,"ld_e4_rdy");  add(0,1,1,LD,E_E5LD,"ld_e5_stop");
    add(1,0,1,ST,E_IDLE,"ld_idle");
    // st with one write wait state, then nop and halt.
    add(0,0,1,ST,E_T0,"st_t0");        add(0,0,1,ST,E_T1,"st_t1");
    add(0,0,1,ST,E_T2,"st_t2");        add(0,0,1,ST,E_DEC,"st_dec");
    add(0,0,1,ST,E_E1L,"st_e1");       add(0,0,1,ST,E_E2L,"st_e2");
    add(0,0,1,ST,E_E3M,"st_e3");       add(0,0,1,ST,E_E4ST,"st_e4");
    add(0,0,0,ST,E_E5ST,"st_e5_wait"); add(0,0,1,ST,E_E5STD,"st_e5_done");
    add(0,0,1,NOP,E_T0,"nop_t0");      add(0,0,1,NOP,E_T1,"nop_t1");
    add(0,0,1,NOP,E_T2,"nop_t2");      add(0,0,1,NOP,E_DECD,"nop_dec");
    add(0,0,1,HALT,E_T0,"halt_t0");    add(0,0,1,HALT,E_T1,"halt_t1");
    add(0,0,1,HALT,E_T2,"halt_t2");    add(0,0,1,HALT,E_DECD,"halt_dec");
    add(1,0,1,BAD,E_IDLE,"halt_idle");
    // undefined opcode, then a run pulse clears illegal for andi.
    add(0,0,1,BAD,E_T0,"bad_t0");      add(0,0,1,BAD,E_T1,"bad_t1");
    add(0,0,1,BAD,E_T2,"bad_t2");      add(0,0,1,BAD,E_DEC,"bad_dec");
    add(0,0,1,ANDI,E_ILL,"bad_idle");  add(1,0,1,ANDI,E_ILL,"ill_run");
    add(0,0,1,ANDI,E_T0,"andi_t0");    add(0,0,1,ANDI,E_T1,"andi_t1");
    add(0,0,1,ANDI,E_T2,"andi_t2");    add(0,0,1,ANDI,E_DEC,"andi_dec");
    add(0,0,1,ANDI,E_E1A,"andi_e1");   add(0,0,1,ANDI,E_E2AND,"andi_e2");
    add(0,1,1,ANDI,E_E3R,"andi_e3");   add(0,0,1,ANDI,E_IDLE,"andi_idle");

    foreach (tbl[i]) begin
      drive(tbl[i].run, tbl[i].stop, tbl[i].mr, tbl[i].opc);
      expect_step(tbl[i].name, tbl[i].exp);
    end

    // Asynchronous reset in the middle of a ld fetch wait.
    do_reset();
    drive(1, 0, 0, LD); expect_step("ar_idle", E_IDLE);
    drive(0, 0, 0, LD); expect_step("ar_t0", E_T0);
    #1; check("ar_t1", E_T1);
    #2; reset = 1'b0;
    #1; check("ar_async", E_IDLE);
    @(posedge clk); #1;
    check("ar_held", E_IDLE);
    reset = 1'b1;
    drive(1, 0, 0, LD); expect_step("ar_rel_idle", E_IDLE);
    drive(0, 0, 1, LD); expect_step("ar_rel_t0", E_T0);

    // Fetch timeout: 15 held T1 cycles, then IDLE with mem_err.
    do_reset();
    drive(1, 0, 0, LD); expect_step("to_idle", E_IDLE);
    drive(0, 0, 0, LD); expect_step("to_t0", E_T0);
    for (int i = 0; i < 15; i++) expect_step($sformatf("to_t1_%0d", i), E_T1);
    expect_step("to_merr", E_MERR);
    drive(1, 0, 0, LD); expect_step("to_merr_run", E_MERR);
    drive(0, 0, 1, LD); expect_step("to_clear_t0", E_T0);

    // mem_ready seen when the count equals WAIT_MAX-1 still completes.
    expect_step("bd_t1", E_T1);
    expect_step("bd_t2", E_T2);
    expect_step("bd_dec", E_DEC);
    expect_step("bd_e1", E_E1L);
    expect_step("bd_e2", E_E2L);
    drive(0, 0, 0, LD); expect_step("bd_e3", E_E3M);
    for (int i = 0; i < 14; i++) expect_step($sformatf("bd_e4_%0d", i), E_E4LD);
    drive(0, 0, 1, LD); expect_step("bd_e4_rdy", E_E4LD);
    drive(0, 1, 1, LD); expect_step("bd_e5", E_E5LD);
    drive(0, 0, 1, LD); expect_step("bd_idle", E_IDLE);

    // addi with stop=0: continuous build fetches again, single-step stops.
    do_reset();
    drive(1, 0, 1, ADDI); expect_step("ai_idle", E_IDLE);
    drive(0, 0, 1, ADDI);
    expect_step("ai_t0", E_T0);
    expect_step("ai_t1", E_T1);
    expect_step("ai_t2", E_T2);
    expect_step("ai_dec", E_DEC);
    expect_step("ai_e1", E_E1A);
    expect_step("ai_e2", E_E2ADD);
    expect_step("ai_e3", E_E3R);
`ifdef CU_SINGLE_STEP_EN
    expect_step("ai_after", E_IDLE);
`else
    expect_step("ai_after", E_T0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
